// File: rtl/csa_acc_pkg.sv
// Shared types and width helper for the streaming carry-save accumulator.
package csa_acc_pkg;

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} csa_acc_state_t;

    function automatic int csa_acc_sw(int m, int n);
        return n + $clog2(m);
    endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder: sum and majority carry of three inputs.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_row.sv
// Combinational 3:2 compressor row; carry vector is returned pre-shifted by one.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);

    logic [W-1:0] maj;

    // The top bit's carry would be shifted out, so only its sum is formed.
    for (genvar i = 0; i < W - 1; i++) begin : g_fa
        FullAdder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (maj[i])
        );
    end

    assign s[W-1]   = a[W-1] ^ b[W-1] ^ c[W-1];
    assign maj[W-1] = 1'b0;
    assign cy       = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Streaming M-operand adder: carry-save accumulation, then a bit-serial ripple
// resolve of S+C into out_sum, presented on a valid/ready output.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int M = 6,
    parameter int N = 4,
    localparam int SW = csa_acc_sw(M, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum
);

    localparam int CW = $clog2(M);
    localparam int KW = $clog2(SW);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(SW - 1);

    csa_acc_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  s_q, s_d;
    logic [SW-1:0]  c_q, c_d;
    logic [KW-1:0]  k_q, k_d;
    logic           r_q, r_d;
    logic           ov_d;
    logic [SW-1:0]  sum_d;

    logic [SW-1:0]  x;
    logic [SW-1:0]  row_s;
    logic [SW-1:0]  row_cy;
    logic           fa_s;
    logic           fa_co;

    assign x        = {{(SW - N){1'b0}}, in_data};
    assign in_ready = (state_q == ACCUM) && !rst;

    csa_row #(.W(SW)) u_row (
        .a  (s_q),
        .b  (c_q),
        .c  (x),
        .s  (row_s),
        .cy (row_cy)
    );

    FullAdder u_fa (
        .a  (s_q[k_q]),
        .b  (c_q[k_q]),
        .ci (r_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;
        k_d     = k_q;
        r_d     = r_q;
        ov_d    = out_valid;
        sum_d   = out_sum;
        case (state_q)
            ACCUM: begin
                if (in_valid && in_ready) begin
                    s_d = row_s;
                    c_d = row_cy;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        k_d     = '0;
                        r_d     = 1'b0;
                        state_d = RESOLVE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESOLVE: begin
                sum_d[k_q] = fa_s;
                // Carry out of the top bit is always zero since the total fits in SW bits.
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    r_d     = 1'b0;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                    r_d = fa_co;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    s_d     = '0;
                    c_d     = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            s_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            r_q       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            c_q       <= c_d;
            k_q       <= k_d;
            r_q       <= r_d;
            out_valid <= ov_d;
            out_sum   <= sum_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator with a sum scoreboard and latency/period checks.
module tb_csa_accumulator;
    import csa_acc_pkg::*;

    localparam int M  = 6;
    localparam int N  = 4;
    localparam int SW = csa_acc_sw(M, N);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q[$];
    int acc_cnt = 0;
    int msum = 0;
    int last_acc = -1;
    int prev_last = -1;
    int pops = 0;
    logic ov_prev = 1'b0;

    csa_accumulator #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            acc_cnt = 0;
            msum    = 0;
            check("in_ready_in_rst", 32'(in_ready), 0);
        end else begin
            if (in_valid && in_ready) begin
                msum += int'(in_data);
                acc_cnt++;
                if (acc_cnt == M) begin
                    q.push_back(msum);
                    prev_last = last_acc;
                    last_acc  = cyc + 1;
                    acc_cnt   = 0;
                    msum      = 0;
                end
            end
            if (out_valid && !ov_prev)
                check("latency", 32'(cyc - last_acc), SW);
            if (out_valid)
                check("in_ready_busy", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
                check("pending_results", 32'(q.size()), 1);
                if (q.size() > 0) check("out_sum", 32'(out_sum), 32'(q.pop_front()));
                pops++;
            end
        end
        ov_prev = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = N'(v);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed=no accept expected=accept of %0d", v);
        end
    endtask

    task automatic gap();
        in_valid = 1'b0;
        in_data  = 4'd9;
        tick();
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 200) begin
            tick();
            n++;
        end
        if (pops < target) begin
            checks++;
            errors++;
            $error("FAIL result_timeout: observed=%0d results expected=%0d", pops, target);
        end
    endtask

    initial begin
        int n;
        int vals[6];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 1);

        // Six max operands back to back.
        for (int i = 0; i < M; i++) send(15);
        in_valid = 1'b0;
        wait_pops(1);

        // Operands with idle cycles interleaved.
        send(1); gap(); send(2); send(3); gap(); send(4); send(5); gap(); send(6);
        in_valid = 1'b0;
        wait_pops(2);

        // All-zero batch.
        for (int i = 0; i < M; i++) send(0);
        in_valid = 1'b0;
        wait_pops(3);

        // Backpressure in DONE.
        out_ready = 1'b0;
        for (int i = 0; i < M; i++) send(15);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_sum", 32'(out_sum), 90);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(out_valid), 0);
        check("bp_release_in_ready", 32'(in_ready), 1);
        check("bp_results", 32'(pops), 4);

        // Abort a partial batch with reset.
        for (int i = 0; i < 3; i++) send(15);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < M; i++) send(1);
        in_valid = 1'b0;
        wait_pops(5);

        // Back-to-back batches with in_valid held high.
        out_ready = 1'b1;
        vals = '{7, 0, 9, 3, 12, 1};
        for (int i = 0; i < M; i++) send(15);
        for (int i = 0; i < M; i++) send(vals[i]);
        in_valid = 1'b0;
        wait_pops(7);
        check("batch_period", 32'(last_acc - prev_last), 32'(M + SW + 1));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
